alarm_ram_arbiter: RTL

//  Shares the single-port 8192x32 on-chip alarm RAM between two Avalon-MM style requesters:
//  m0 (CPU data master) and m1 (alarm/display scanner). Grants one access per cycle,

---
 rtl/alarm_pkg.sv | 29 ++
 rtl/alarm_rr_grant.sv | 112 +++++++++++
 rtl/alarm_ram_arbiter.sv | 139 +++++++++++++
 3 files changed

// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm RAM arbiter: default widths, hold counter
// type and the arbitration state encoding.
package alarm_pkg;

    localparam int ADDR_W_DEF   = 13;
    localparam int DATA_W_DEF   = 32;
    localparam int MAX_HOLD_DEF = 4;

    // Hold counter is 4 bits wide so MAX_HOLD may range over 1..15.
    typedef logic [3:0] hold_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_e;

    // Saturating increment of the hold counter, capped at the hold limit.
    function automatic hold_t hold_inc(input hold_t cnt, input hold_t limit);
        hold_t res;
        if (cnt >= limit) begin
            res = limit;
        end else begin
            res = cnt + 4'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/alarm_rr_grant.sv
// Two-way round-robin grant with a bounded hold window. The grant is decided
// combinationally from the registered owner state and the live requests; the
// owner, last winner and run length are registered.
module alarm_rr_grant
    import alarm_pkg::*;
#(
    parameter int MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic req0,
    input  logic req1,
    output logic grant0,
    output logic grant1
);

    localparam hold_t MAX_HOLD_C = hold_t'(MAX_HOLD);

    arb_state_e state_r;
    arb_state_e state_next_s;
    hold_t      hold_r;
    hold_t      hold_next_s;
    logic       last_r;
    logic       last_next_s;
    logic       grant0_s;
    logic       grant1_s;

    // State register: owner, consecutive-grant count and last winner.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            hold_r  <= 4'd0;
            last_r  <= 1'b1;
        end else begin
            state_r <= state_next_s;
            hold_r  <= hold_next_s;
            last_r  <= last_next_s;
        end
    end

    // Next-state logic: follow whichever port won this cycle.
    always_comb begin
        state_next_s = IDLE;
        hold_next_s  = 4'd0;
        last_next_s  = last_r;
        if (grant0_s) begin
            state_next_s = OWN0;
            last_next_s  = 1'b0;
            if (state_r == OWN0) begin
                hold_next_s = hold_inc(hold_r, MAX_HOLD_C);
            end else begin
                hold_next_s = 4'd1;
            end
        end else if (grant1_s) begin
            state_next_s = OWN1;
            last_next_s  = 1'b1;
            if (state_r == OWN1) begin
                hold_next_s = hold_inc(hold_r, MAX_HOLD_C);
            end else begin
                hold_next_s = 4'd1;
            end
        end else begin
            state_next_s = IDLE;
            hold_next_s  = 4'd0;
        end
    end

    // Output logic: pick the winner; nothing is granted while in reset.
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if (reset) begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (req0 && req1) begin
                        // Tie: the port that did not win last time goes first.
                        grant0_s = last_r;
                        grant1_s = ~last_r;
                    end else begin
                        grant0_s = req0;
                        grant1_s = req1 & ~req0;
                    end
                end
                OWN0: begin
                    if (req0 && (!req1 || hold_r < MAX_HOLD_C)) begin
                        grant0_s = 1'b1;
                    end else begin
                        grant1_s = req1;
                    end
                end
                OWN1: begin
                    if (req1 && (!req0 || hold_r < MAX_HOLD_C)) begin
                        grant1_s = 1'b1;
                    end else begin
                        grant0_s = req0;
                    end
                end
                default: begin
                    grant0_s = 1'b0;
                    grant1_s = 1'b0;
                end
            endcase
        end
    end

    assign grant0 = grant0_s;
    assign grant1 = grant1_s;

endmodule

// File: rtl/alarm_ram_arbiter.sv
// Shares the single-port alarm RAM between the CPU data master (m0) and the
// alarm/display scanner (m1). One access per cycle; the winner's request is
// steered to the RAM in the same cycle and read data comes back one cycle
// later on the port that issued the read.
module alarm_ram_arbiter
    import alarm_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_W-1:0]     m0_address,
    input  logic [DATA_W/8-1:0]   m0_byteenable,
    input  logic                  m0_read,
    input  logic                  m0_write,
    input  logic [DATA_W-1:0]     m0_writedata,
    output logic                  m0_waitrequest,
    output logic [DATA_W-1:0]     m0_readdata,
    output logic                  m0_readdatavalid,
    input  logic [ADDR_W-1:0]     m1_address,
    input  logic [DATA_W/8-1:0]   m1_byteenable,
    input  logic                  m1_read,
    input  logic                  m1_write,
    input  logic [DATA_W-1:0]     m1_writedata,
    output logic                  m1_waitrequest,
    output logic [DATA_W-1:0]     m1_readdata,
    output logic                  m1_readdatavalid,
    output logic [ADDR_W-1:0]     ram_address,
    output logic [DATA_W/8-1:0]   ram_byteenable,
    output logic                  ram_chipselect,
    output logic                  ram_write,
    output logic [DATA_W-1:0]     ram_writedata,
    output logic                  ram_clken,
    input  logic [DATA_W-1:0]     ram_readdata
);

    logic              req0_s;
    logic              req1_s;
    logic              grant0_s;
    logic              grant1_s;
    logic              rd_accept_s;
    logic              rd_port_s;
    logic              pend_valid_r;
    logic              pend_port_r;
    logic              rdv0_s;
    logic              rdv1_s;
    logic [DATA_W-1:0] held0_r;
    logic [DATA_W-1:0] held1_r;

    // A write-plus-read on one port is still a single request; the write wins.
    assign req0_s = m0_read | m0_write;
    assign req1_s = m1_read | m1_write;

    alarm_rr_grant #(
        .MAX_HOLD (MAX_HOLD)
    ) u_grant (
        .clk    (clk),
        .reset  (reset),
        .req0   (req0_s),
        .req1   (req1_s),
        .grant0 (grant0_s),
        .grant1 (grant1_s)
    );

    // Steer the winning request onto the RAM port and flag accepted reads.
    always_comb begin
        ram_address    = '0;
        ram_byteenable = '0;
        ram_chipselect = 1'b0;
        ram_write      = 1'b0;
        ram_writedata  = '0;
        rd_accept_s    = 1'b0;
        rd_port_s      = 1'b0;
        if (grant0_s) begin
            ram_address    = m0_address;
            ram_byteenable = m0_byteenable;
            ram_chipselect = 1'b1;
            ram_write      = m0_write;
            ram_writedata  = m0_writedata;
            rd_accept_s    = ~m0_write;
            rd_port_s      = 1'b0;
        end else if (grant1_s) begin
            ram_address    = m1_address;
            ram_byteenable = m1_byteenable;
            ram_chipselect = 1'b1;
            ram_write      = m1_write;
            ram_writedata  = m1_writedata;
            rd_accept_s    = ~m1_write;
            rd_port_s      = 1'b1;
        end else begin
            ram_chipselect = 1'b0;
            ram_write      = 1'b0;
        end
    end

    assign ram_clken = 1'b1;

    // Only a requesting loser is stalled; every port stalls while in reset.
    assign m0_waitrequest = reset | (req0_s & ~grant0_s);
    assign m1_waitrequest = reset | (req1_s & ~grant1_s);

    // One-deep read-return tag: the RAM answers exactly one cycle later, so a
    // single entry sustains one read per cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_valid_r <= 1'b0;
            pend_port_r  <= 1'b0;
        end else begin
            pend_valid_r <= rd_accept_s;
            pend_port_r  <= rd_port_s;
        end
    end

    assign rdv0_s = pend_valid_r & ~pend_port_r;
    assign rdv1_s = pend_valid_r &  pend_port_r;

    // Hold the most recent returned word per port for cycles without a return.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            held0_r <= '0;
            held1_r <= '0;
        end else begin
            if (rdv0_s) begin
                held0_r <= ram_readdata;
            end
            if (rdv1_s) begin
                held1_r <= ram_readdata;
            end
        end
    end

    assign m0_readdatavalid = rdv0_s;
    assign m1_readdatavalid = rdv1_s;
    assign m0_readdata      = rdv0_s ? ram_readdata : held0_r;
    assign m1_readdata      = rdv1_s ? ram_readdata : held1_r;

endmodule
